// File: rtl/rvfi_mem_pkg.sv
// Shared types, constants and address helpers for the RVFI memory responder.
// Imported by the top level and by the backing-window store.
package rvfi_mem_pkg;

  typedef enum logic [1:0] {
    MEM_RANDOM  = 2'd0,
    MEM_BOUNDED = 2'd1,
    MEM_FIXED   = 2'd2
  } mem_mode_e;

  localparam int WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_SAT = 4'd15;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Offset compare keeps the check correct even when base+span would overflow.
  function automatic logic win_hit(input logic [31:0] addr,
                                   input logic [31:0] base,
                                   input logic [31:0] span);
    logic [31:0] off;
    off = addr - base;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/rvfi_mem_window.sv
// Write-coherent backing window: DEPTH words with per-word valid bits,
// byte-strobed writes and a combinational read port on the request address.
module rvfi_mem_window
  import rvfi_mem_pkg::*;
#(
  parameter logic [31:0] WIN_BASE = 32'h0000_1000,
  parameter int          DEPTH    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_word_o
);

  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  logic [31:0]      mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic             hit_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      word_d;

  // Decode the address and merge strobed lanes into the addressed word.
  always_comb begin
    hit_s  = win_hit(addr_i, WIN_BASE, SPAN);
    idx_s  = addr_i[2 +: IDX_W];
    word_d = mem_q[idx_s];
    for (int b = 0; b < 4; b++) begin
      word_d[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : mem_q[idx_s][8*b +: 8];
    end
  end

  // Store update; data is cleared too so unwritten lanes read as zero.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i && hit_s) begin
      mem_q[idx_s] <= word_d;
      vld_q[idx_s] <= 1'b1;
    end
  end

  assign rd_hit_o  = hit_s && vld_q[idx_s];
  assign rd_word_o = mem_q[idx_s];

endmodule

// File: rtl/rvfi_mem_responder.sv
// Memory-side responder for valid/ready cores: shapes free ready/rdata inputs
// into a bus response, keeps a coherent window and flags core-side handshake violations.
module rvfi_mem_responder
  import rvfi_mem_pkg::*;
#(
  parameter int          MODE     = 1,
  parameter int          MAX_WAIT = 3,
  parameter int          LATENCY  = 2,
  parameter logic [31:0] WIN_BASE = 32'h0000_1000,
  parameter int          DEPTH    = 16,
  parameter int          CNT_W    = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             trap,
  input  logic             mem_valid,
  input  logic             mem_instr,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  input  logic             rand_ready,
  input  logic [31:0]      rand_rdata,
  output logic [3:0]       wait_cnt,
  output logic [CNT_W-1:0] xfer_count,
  output logic             proto_err
);

  localparam mem_mode_e         MODE_E     = mem_mode_e'(2'(MODE));
  localparam logic [WAIT_W-1:0] MAX_WAIT_L = 4'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] LATENCY_L  = 4'(LATENCY);
  localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  xfer_q, xfer_d;
  logic              err_q, err_d;
  logic [31:0]       addr_q, wdata_q;
  logic [3:0]        wstrb_q;
  logic              instr_q, trap_q;
  logic              ready_s, hs_s, chg_s;
  logic              rd_hit_s;
  logic [31:0]       rd_word_s;

  // Ready generation; trap falls back to the free source with no forcing.
  always_comb begin
    ready_s = 1'b0;
    if (!resetn || !mem_valid) begin
      ready_s = 1'b0;
    end else if (trap) begin
      ready_s = rand_ready;
    end else begin
      case (MODE_E)
        MEM_BOUNDED: ready_s = rand_ready || (wait_q >= MAX_WAIT_L);
        MEM_FIXED:   ready_s = (wait_q == LATENCY_L);
        default:     ready_s = rand_ready;
      endcase
    end
  end

  assign hs_s = mem_valid && ready_s;

  rvfi_mem_window #(
    .WIN_BASE (WIN_BASE),
    .DEPTH    (DEPTH)
  ) u_window (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .we_i      (hs_s && (mem_wstrb != 4'b0000)),
    .addr_i    (mem_addr),
    .wdata_i   (mem_wdata),
    .wstrb_i   (mem_wstrb),
    .rd_hit_o  (rd_hit_s),
    .rd_word_o (rd_word_s)
  );

  // Read data: stored word for valid window hits on reads, free data otherwise.
  always_comb begin
    mem_rdata = 32'h0000_0000;
    if (!resetn) begin
      mem_rdata = 32'h0000_0000;
    end else if ((mem_wstrb == 4'b0000) && rd_hit_s) begin
      mem_rdata = rd_word_s;
    end else begin
      mem_rdata = rand_rdata;
    end
  end

  // Next-state for wait counter, request state, transfer counter and error flag.
  always_comb begin
    wait_d  = wait_q;
    state_d = ST_IDLE;
    xfer_d  = xfer_q;
    err_d   = err_q;
    chg_s   = (mem_addr != addr_q) || (mem_wdata != wdata_q) ||
              (mem_wstrb != wstrb_q) || (mem_instr != instr_q);

    if (trap) begin
      wait_d = wait_q;
    end else if (!mem_valid || hs_s) begin
      wait_d = 4'd0;
    end else if (wait_q != WAIT_SAT) begin
      wait_d = wait_q + 4'd1;
    end else begin
      wait_d = wait_q;
    end

    if (!mem_valid) begin
      state_d = ST_IDLE;
    end else if (hs_s) begin
      state_d = ST_DONE;
    end else begin
      state_d = ST_WAIT;
    end

    if (hs_s) begin
      xfer_d = xfer_q + CNT_ONE;
    end else begin
      xfer_d = xfer_q;
    end

    // A stalled request must stay asserted and unchanged until accepted.
    if ((state_q == ST_WAIT) && !trap && !trap_q && (!mem_valid || chg_s)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers; reset drops any pending request without flagging it.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wait_q  <= 4'd0;
      state_q <= ST_IDLE;
      xfer_q  <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      instr_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      state_q <= state_d;
      xfer_q  <= xfer_d;
      err_q   <= err_d;
      addr_q  <= mem_addr;
      wdata_q <= mem_wdata;
      wstrb_q <= mem_wstrb;
      instr_q <= mem_instr;
      trap_q  <= trap;
    end
  end

  assign mem_ready  = ready_s;
  assign wait_cnt   = wait_q;
  assign xfer_count = xfer_q;
  assign proto_err  = err_q;

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Scoreboard bench for rvfi_mem_responder: a bounded-wait instance and a
// fixed-latency instance share the request bus, each with its own valid.
module tb_rvfi_mem_responder;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, trap, valid_b, valid_f, mem_instr, rand_ready;
  logic [31:0] mem_addr, mem_wdata, rand_rdata;
  logic [3:0]  mem_wstrb;
  logic        ready_b, ready_f, err_b, err_f;
  logic [31:0] rdata_b, rdata_f;
  logic [3:0]  wait_b, wait_f;
  logic [15:0] xfer_b, xfer_f;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] model_mem [16];
  logic [15:0] model_vld;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] r;
  } op_t;
  op_t ops [12];

  rvfi_mem_responder #(.MODE(1), .MAX_WAIT(3), .LATENCY(2), .WIN_BASE(32'h0000_1000),
                       .DEPTH(16), .CNT_W(16)) u_bnd (
    .clock(clock), .resetn(resetn), .trap(trap), .mem_valid(valid_b), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_b),
    .mem_rdata(rdata_b), .rand_ready(rand_ready), .rand_rdata(rand_rdata), .wait_cnt(wait_b),
    .xfer_count(xfer_b), .proto_err(err_b));

  rvfi_mem_responder #(.MODE(2), .MAX_WAIT(3), .LATENCY(2), .WIN_BASE(32'h0000_1000),
                       .DEPTH(16), .CNT_W(16)) u_fix (
    .clock(clock), .resetn(resetn), .trap(trap), .mem_valid(valid_f), .mem_instr(mem_instr),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(ready_f),
    .mem_rdata(rdata_f), .rand_ready(rand_ready), .rand_rdata(rand_rdata), .wait_cnt(wait_f),
    .xfer_count(xfer_f), .proto_err(err_f));

  task automatic model_clear();
    model_vld = 16'h0000;
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0000_0000;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic [31:0] rnd);
    logic [31:0] off;
    off = (a - 32'h0000_1000) >> 2;
    if (a >= 32'h0000_1000 && a < 32'h0000_1040 && model_vld[off[3:0]]) return model_mem[off[3:0]];
    return rnd;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off;
    off = (a - 32'h0000_1000) >> 2;
    if (a >= 32'h0000_1000 && a < 32'h0000_1040) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[off[3:0]][8*b +: 8] = d[8*b +: 8];
      model_vld[off[3:0]] = 1'b1;
    end
  endtask

  // Drive one request on the bounded instance; starts and ends just after a rising edge.
  task automatic bnd_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic rr, output int cyc, output logic [31:0] rd,
                          output logic [3:0] wc);
    mem_addr = a; mem_wdata = wd; mem_wstrb = ws; rand_ready = rr; valid_b = 1'b1;
    cyc = -1; rd = 32'h0; wc = 4'h0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (ready_b === 1'b1) begin
        cyc = i; rd = rdata_b; wc = wait_b;
        break;
      end
    end
    @(posedge clock); #1;
    valid_b = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; trap = 1'b0; valid_b = 1'b1; valid_f = 1'b1; rand_ready = 1'b1;
    rand_rdata = 32'hDEAD_BEEF; mem_addr = 32'h0000_1000; mem_wdata = 32'h0; mem_wstrb = 4'h0;
    mem_instr = 1'b0;
    @(negedge clock);
    n_cmp++; if (ready_b !== 1'b0) begin n_err++; $display("FAIL reset_ready_b: got %b want 0", ready_b); end
    n_cmp++; if (ready_f !== 1'b0) begin n_err++; $display("FAIL reset_ready_f: got %b want 0", ready_f); end
    n_cmp++; if (rdata_b !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata_b); end
    @(posedge clock); #1;
    valid_b = 1'b0; valid_f = 1'b0; rand_ready = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    model_clear();
    @(negedge clock);
    n_cmp++; if (wait_b !== 4'd0) begin n_err++; $display("FAIL reset_wait: got %0d want 0", wait_b); end
    n_cmp++; if (xfer_b !== 16'd0) begin n_err++; $display("FAIL reset_xfer: got %0d want 0", xfer_b); end
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_b); end
    n_cmp++; if (xfer_f !== 16'd0 || err_f !== 1'b0) begin n_err++; $display("FAIL reset_fix: got xfer=%0d err=%b want 0 0", xfer_f, err_f); end
    @(posedge clock); #1;
  endtask

  task automatic test_bounded();
    int cyc; logic [31:0] rd, exp; logic [3:0] wc;
    rand_rdata = 32'h1234_5678;
    sb_q.push_back(32'h1234_5678);
    bnd_xfer(32'h0000_3000, 32'h0, 4'h0, 1'b0, cyc, rd, wc);
    n_cmp++; if (cyc !== 4) begin n_err++; $display("FAIL bounded_cycle: got %0d want 4", cyc); end
    n_cmp++; if (wc !== 4'd3) begin n_err++; $display("FAIL bounded_wait: got %0d want 3", wc); end
    exp = sb_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL bounded_rdata: got %h want %h", rd, exp); end
    @(negedge clock);
    n_cmp++; if (xfer_b !== 16'd1) begin n_err++; $display("FAIL bounded_xfer: got %0d want 1", xfer_b); end
    n_cmp++; if (wait_b !== 4'd0) begin n_err++; $display("FAIL bounded_wait_clr: got %0d want 0", wait_b); end
    @(posedge clock); #1;
  endtask

  task automatic test_fixed();
    logic [5:0] seen; logic [31:0] exp;
    seen = 6'b000000;
    mem_addr = 32'h0000_3004; mem_wstrb = 4'h0; rand_rdata = 32'h5A5A_0001;
    rand_ready = 1'b1; valid_f = 1'b1;
    sb_q.push_back(32'h5A5A_0001);
    sb_q.push_back(32'h5A5A_0001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (ready_f === 1'b1) begin
        seen[i] = 1'b1;
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hXXXX_XXXX;
        n_cmp++; if (rdata_f !== exp) begin n_err++; $display("FAIL fixed_rdata: got %h want %h", rdata_f, exp); end
      end
      @(posedge clock); #1;
      rand_ready = ~rand_ready;
    end
    valid_f = 1'b0;
    n_cmp++; if (seen !== 6'b100100) begin n_err++; $display("FAIL fixed_ready_cycles: got %b want 100100", seen); end
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL fixed_pending: got %0d want 0", sb_q.size()); end
    sb_q.delete();
    @(negedge clock);
    n_cmp++; if (xfer_f !== 16'd2) begin n_err++; $display("FAIL fixed_xfer: got %0d want 2", xfer_f); end
    @(posedge clock); #1;
  endtask

  task automatic test_window();
    int cyc; logic [31:0] rd, exp; logic [3:0] wc;
    ops[0]  = '{32'h0000_1004, 32'hAABB_CCDD, 4'b0101, 32'h0101_0101};
    ops[1]  = '{32'h0000_1004, 32'h0,         4'b0000, 32'h1111_1111};
    ops[2]  = '{32'h0000_2000, 32'h0,         4'b0000, 32'h7766_5544};
    ops[3]  = '{32'h0000_1008, 32'h0,         4'b0000, 32'h2222_3333};
    ops[4]  = '{32'h0000_1006, 32'h9900_0000, 4'b1000, 32'h0000_0042};
    ops[5]  = '{32'h0000_1004, 32'h0,         4'b0000, 32'hABCD_ABCD};
    ops[6]  = '{32'h0000_103C, 32'h0F0E_0D0C, 4'b1111, 32'h0000_0007};
    ops[7]  = '{32'h0000_103C, 32'h0,         4'b0000, 32'h0000_0044};
    ops[8]  = '{32'h0000_1040, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0009};
    ops[9]  = '{32'h0000_1040, 32'h0,         4'b0000, 32'h1357_2468};
    ops[10] = '{32'h0000_0FFC, 32'h0,         4'b0000, 32'h0246_8ACE};
    ops[11] = '{32'h0000_1000, 32'h0,         4'b0000, 32'hFEED_F00D};
    for (int i = 0; i < 12; i++) begin
      rand_rdata = ops[i].r;
      sb_q.push_back((ops[i].s != 4'h0) ? ops[i].r : model_read(ops[i].a, ops[i].r));
      if (ops[i].s != 4'h0) model_write(ops[i].a, ops[i].d, ops[i].s);
      bnd_xfer(ops[i].a, ops[i].d, ops[i].s, 1'b1, cyc, rd, wc);
      exp = sb_q.pop_front();
      n_cmp++; if (cyc !== 1 || rd !== exp) begin n_err++; $display("FAIL window_op%0d: got cyc=%0d rdata=%h want cyc=1 rdata=%h", i, cyc, rd, exp); end
    end
    @(negedge clock);
    n_cmp++; if (xfer_b !== 16'd13) begin n_err++; $display("FAIL window_xfer: got %0d want 13", xfer_b); end
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL window_err: got %b want 0", err_b); end
    @(posedge clock); #1;
  endtask

  task automatic test_proto();
    mem_addr = 32'h0000_1000; mem_wstrb = 4'h0; rand_ready = 1'b0; valid_b = 1'b1;
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL proto_before: got %b want 0", err_b); end
    @(posedge clock); #1;
    mem_addr = 32'h0000_1008;
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL proto_same_cycle: got %b want 0", err_b); end
    @(posedge clock); #1;
    valid_b = 1'b0;
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b1) begin n_err++; $display("FAIL proto_flag: got %b want 1", err_b); end
    repeat (4) @(posedge clock);
    #1;
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b1) begin n_err++; $display("FAIL proto_sticky: got %b want 1", err_b); end
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b1;
    model_clear();
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL proto_reset: got %b want 0", err_b); end
    @(posedge clock); #1;
  endtask

  task automatic test_trap();
    mem_addr = 32'h0000_1000; mem_wstrb = 4'h0; rand_ready = 1'b0; trap = 1'b0; valid_b = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    trap = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      n_cmp++; if (ready_b !== 1'b0 || wait_b !== 4'd3) begin n_err++; $display("FAIL trap_cycle%0d: got ready=%b wait=%0d want ready=0 wait=3", i, ready_b, wait_b); end
      @(posedge clock); #1;
    end
    trap = 1'b0; valid_b = 1'b0;
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b0) begin n_err++; $display("FAIL trap_err: got %b want 0", err_b); end
    n_cmp++; if (xfer_b !== 16'd0) begin n_err++; $display("FAIL trap_xfer: got %0d want 0", xfer_b); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    int cyc; logic [31:0] rd, exp; logic [3:0] wc;
    mem_addr = 32'h0000_1000; mem_wdata = 32'h5555_5555; mem_wstrb = 4'hF;
    rand_ready = 1'b0; rand_rdata = 32'h0BAD_F00D; valid_b = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(negedge clock);
    n_cmp++; if (ready_b !== 1'b0 || rdata_b !== 32'h0) begin n_err++; $display("FAIL midreset_out: got ready=%b rdata=%h want 0 0", ready_b, rdata_b); end
    @(posedge clock); #1;
    valid_b = 1'b0; resetn = 1'b1;
    model_clear();
    @(negedge clock);
    n_cmp++; if (wait_b !== 4'd0 || xfer_b !== 16'd0 || err_b !== 1'b0) begin n_err++; $display("FAIL midreset_cnt: got wait=%0d xfer=%0d err=%b want 0 0 0", wait_b, xfer_b, err_b); end
    @(posedge clock); #1;
    sb_q.push_back(model_read(32'h0000_1000, 32'h0BAD_F00D));
    bnd_xfer(32'h0000_1000, 32'h0, 4'h0, 1'b1, cyc, rd, wc);
    exp = sb_q.pop_front();
    n_cmp++; if (rd !== exp) begin n_err++; $display("FAIL midreset_store: got %h want %h", rd, exp); end
    @(negedge clock);
    n_cmp++; if (err_b !== 1'b0 || xfer_b !== 16'd1) begin n_err++; $display("FAIL midreset_after: got err=%b xfer=%0d want 0 1", err_b, xfer_b); end
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_bounded();
    test_fixed();
    test_window();
    test_proto();
    test_trap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rvfi_mem_responder.md
Name: rvfi_mem_responder

Overview:
Parametrised memory-side responder for formal and simulation harnesses around cores with a valid/ready memory bus (picorv32 style). Converts free (unconstrained) ready/rdata inputs into a bus response with three selectable wait modes. Keeps a small write-coherent backing window so loads after stores are consistent. Checks the core side of the handshake and raises a sticky protocol-error flag.

Parameters:
MODE, 1, 0 = pure random ready; 1 = bounded wait (ready forced after MAX_WAIT); 2 = fixed latency.
MAX_WAIT, 3, mode 1: max consecutive stalled cycles before ready is forced (1..15).
LATENCY, 2, mode 2: stall cycles before ready (0..15).
WIN_BASE, 32'h0000_1000, byte base of backing window (DEPTH*4-aligned).
DEPTH, 16, words in backing window (power of 2, 2..256).
CNT_W, 16, width of transfer counter.

Ports:
clock  in  1  system clock
resetn  in  1  synchronous active-low reset
trap  in  1  core trap; suspends forcing and checking
mem_valid  in  1  core request valid
mem_instr  in  1  instruction fetch qualifier
mem_addr  in  32  byte address
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_ready  out  1  response/accept
mem_rdata  out  32  read data
rand_ready  in  1  free ready source
rand_rdata  in  32  free read-data source
wait_cnt  out  4  current stalled-cycle count
xfer_count  out  CNT_W  completed handshakes
proto_err  out  1  sticky handshake violation

Behaviour:
- Reset (resetn=0 at clock edge): wait_cnt=0, xfer_count=0, proto_err=0, all window valid bits cleared. While resetn=0, mem_ready=0 and mem_rdata=0 (combinational gating).
- Handshake: transfer completes in any cycle with mem_valid && mem_ready. mem_ready is combinational; it is never high while mem_valid=0.
- mem_ready (trap=0): mode 0 = rand_ready; mode 1 = rand_ready || (wait_cnt >= MAX_WAIT); mode 2 = (wait_cnt == LATENCY), rand_ready ignored. If trap=1: mem_ready = rand_ready in every mode (no forcing).
- wait_cnt: cleared on a handshake or when mem_valid=0; incremented when mem_valid && !mem_ready; saturates at 15; held while trap=1.
- xfer_count: +1 per handshake, wraps modulo 2^CNT_W.
- Window hit: WIN_BASE <= mem_addr < WIN_BASE+DEPTH*4; index = mem_addr[2 +: log2(DEPTH)]; mem_addr[1:0] ignored.
- Writes (wstrb!=0) on handshake with hit: update only strobed byte lanes; set word valid bit. Misses are discarded.
- Reads: mem_rdata = stored word if hit and valid bit set, else rand_rdata. Write handshakes drive rand_rdata. Read and write to the same word never coincide (one request per cycle).
- Protocol check: register pending = mem_valid && !mem_ready, plus addr/wdata/wstrb/instr. If pending was 1 and now mem_valid=0 or any registered field differs: proto_err <= 1. Suppressed when trap=1 either cycle. Clears only on reset.
- Reset mid-transfer: pending request dropped, no store update, no error.
- State per request: IDLE (no valid), WAIT (valid, stalled), DONE (handshake cycle; returns to IDLE or WAIT for a back-to-back request).

Decomposition:
- Package rvfi_mem_pkg: mode enum (MEM_RANDOM, MEM_BOUNDED, MEM_FIXED), wait-counter width, window-hit function.
- Sub-module rvfi_mem_window: DEPTH-word byte-strobed store with valid bits, hit/index decode, read mux. The top level holds the wait counter, ready logic, protocol checker and transfer counter.

Test Plan:
- MODE=1, MAX_WAIT=3, mem_valid held, rand_ready=0 -> mem_ready high on the 4th valid cycle (wait_cnt=3); xfer_count=1.
- MODE=2, LATENCY=2, two back-to-back reads -> ready on cycles 3 and 6 of valid; rand_ready toggling has no effect.
- Write 32'hAABBCCDD to 0x1004 with wstrb=4'b0101, then read 0x1004 -> rdata bytes 2 and 0 = BB, DD; bytes 3 and 1 = unwritten bytes (0 after reset) since the word is now valid; read of 0x2000 returns rand_rdata.
- Stalled request, mem_addr changes 0x1000->0x1008 before ready -> proto_err=1 next cycle, stays 1 until resetn=0.
- MODE=1, trap=1, rand_ready=0 for 10 cycles -> mem_ready stays 0, wait_cnt frozen, proto_err stays 0.
- resetn=0 during WAIT with pending write to 0x1000 -> mem_ready=0, store unchanged, all counters 0 after release.
